// File: rtl/uart_cmd_dispatcher.sv
// uart_cmd_dispatcher
// Builds fixed-length command frames from the UART byte stream, routes each
// frame to its axis command registers and tracks a per-axis pending flag that
// clears when the axis controller reports it has started the move.
module uart_cmd_dispatcher #(
  parameter int NUM_AXES       = 10,
  parameter int FRAME_BYTES    = 5,
  parameter int TIMEOUT_CYCLES = 2400000
) (
  input  logic                   CLK,
  input  logic                   reset_n,
  input  logic                   rx_valid,
  input  logic [7:0]             rx_data,
  input  logic [NUM_AXES-1:0]    motor_active,
  output logic [15*NUM_AXES-1:0] divider_o,
  output logic [15*NUM_AXES-1:0] steps_o,
  output logic [NUM_AXES-1:0]    dir_o,
  output logic [NUM_AXES-1:0]    pending_o,
  output logic                   frame_ok,
  output logic                   frame_drop,
  output logic [7:0]             drop_cnt
);

  localparam int CMD_W = 8 * FRAME_BYTES;
  localparam int IDX_W = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  // framing state
  logic [CMD_W-1:0] cmd_q, cmd_d;
  logic [IDX_W-1:0] idx_q, idx_d, idx_cur;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic             done_q, done_d;
  logic             expire;

  // per-axis command state
  logic [NUM_AXES-1:0]    act_q;
  logic [NUM_AXES-1:0]    rise;
  logic [15*NUM_AXES-1:0] div_q, div_d;
  logic [15*NUM_AXES-1:0] steps_q, steps_d;
  logic [NUM_AXES-1:0]    dir_q, dir_d;
  logic [NUM_AXES-1:0]    pend_q, pend_d;
  logic                   ok_q, ok_d;
  logic                   drop_q, drop_d;
  logic [7:0]             dcnt_q, dcnt_d;
  logic [3:0]             ax;
  logic                   hit, busy;

  // Byte assembly with inter-byte timeout; a byte arriving on the expiry
  // cycle starts a fresh frame rather than extending the stale one.
  always_comb begin
    expire   = (to_cnt_q == '0) && (idx_q != '0);
    cmd_d    = cmd_q;
    idx_d    = idx_q;
    idx_cur  = expire ? '0 : idx_q;
    to_cnt_d = to_cnt_q;
    done_d   = 1'b0;
    if (rx_valid) begin
      cmd_d    = {rx_data, cmd_q[CMD_W-1:8]};
      to_cnt_d = TO_W'(TIMEOUT_CYCLES - 1);
      if (idx_cur == IDX_W'(FRAME_BYTES - 1)) begin
        idx_d  = '0;
        done_d = 1'b1;
      end else begin
        idx_d = idx_cur + 1'b1;
      end
    end else begin
      if (to_cnt_q != '0) to_cnt_d = to_cnt_q - 1'b1;
      if (expire) idx_d = '0;
    end
  end

  // Framing registers.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      cmd_q    <= '0;
      idx_q    <= '0;
      to_cnt_q <= '0;
      done_q   <= 1'b0;
    end else begin
      cmd_q    <= cmd_d;
      idx_q    <= idx_d;
      to_cnt_q <= to_cnt_d;
      done_q   <= done_d;
    end
  end

  // Start-edge clears are applied before the accept check, so a start and a
  // new frame for the same axis in one cycle always accepts the new frame.
  always_comb begin
    rise    = motor_active & ~act_q;
    ax      = cmd_q[3:0];
    div_d   = div_q;
    steps_d = steps_q;
    dir_d   = dir_q;
    pend_d  = pend_q;
    ok_d    = 1'b0;
    drop_d  = 1'b0;
    dcnt_d  = dcnt_q;
    hit     = 1'b0;
    busy    = 1'b0;
    for (int i = 0; i < NUM_AXES; i++) begin
      if (rise[i]) begin
        pend_d[i]           = 1'b0;
        steps_d[15*i +: 15] = '0;
      end
    end
    for (int i = 0; i < NUM_AXES; i++) begin
      if (ax == 4'(i)) begin
        hit  = 1'b1;
        busy = pend_d[i];
      end
    end
    if (done_q) begin
      if (hit && !busy) begin
        ok_d = 1'b1;
        for (int i = 0; i < NUM_AXES; i++) begin
          if (ax == 4'(i)) begin
            div_d[15*i +: 15]   = cmd_q[18:4];
            steps_d[15*i +: 15] = cmd_q[33:19];
            dir_d[i]            = cmd_q[34];
            pend_d[i]           = 1'b1;
          end
        end
      end else begin
        drop_d = 1'b1;
        if (dcnt_q != 8'hFF) dcnt_d = dcnt_q + 8'd1;
      end
    end
  end

  // Per-axis command registers and status pulses.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      act_q   <= '0;
      div_q   <= '0;
      steps_q <= '0;
      dir_q   <= '0;
      pend_q  <= '0;
      ok_q    <= 1'b0;
      drop_q  <= 1'b0;
      dcnt_q  <= '0;
    end else begin
      act_q   <= motor_active;
      div_q   <= div_d;
      steps_q <= steps_d;
      dir_q   <= dir_d;
      pend_q  <= pend_d;
      ok_q    <= ok_d;
      drop_q  <= drop_d;
      dcnt_q  <= dcnt_d;
    end
  end

  assign divider_o  = div_q;
  assign steps_o    = steps_q;
  assign dir_o      = dir_q;
  assign pending_o  = pend_q;
  assign frame_ok   = ok_q;
  assign frame_drop = drop_q;
  assign drop_cnt   = dcnt_q;

endmodule

// File: tb/tb_uart_cmd_dispatcher.sv
// Bench for uart_cmd_dispatcher: frame table, hand-written corner sequences
// and a randomized run against a per-axis behavioural model.
module tb_uart_cmd_dispatcher;
  localparam int NA = 10;
  localparam int FB = 5;
  localparam int TO = 40;

  logic                CLK = 1'b0;
  logic                reset_n = 1'b0;
  logic                rx_valid = 1'b0;
  logic [7:0]          rx_data = 8'h00;
  logic [NA-1:0]       motor_active = '0;
  logic [15*NA-1:0]    divider_o, steps_o;
  logic [NA-1:0]       dir_o, pending_o;
  logic                frame_ok, frame_drop;
  logic [7:0]          drop_cnt;

  uart_cmd_dispatcher #(.NUM_AXES(NA), .FRAME_BYTES(FB), .TIMEOUT_CYCLES(TO)) dut (
    .CLK(CLK), .reset_n(reset_n), .rx_valid(rx_valid), .rx_data(rx_data),
    .motor_active(motor_active), .divider_o(divider_o), .steps_o(steps_o),
    .dir_o(dir_o), .pending_o(pending_o), .frame_ok(frame_ok),
    .frame_drop(frame_drop), .drop_cnt(drop_cnt));

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  // behavioural model: one record per axis
  logic [14:0] m_div[NA];
  logic [14:0] m_steps[NA];
  logic        m_dir[NA];
  logic        m_pend[NA];
  int          m_dcnt;

  typedef struct {
    int          start_ax;
    int          ax;
    logic [14:0] dv;
    logic [14:0] st;
    logic        dr;
    logic        exp_ok;
    logic [7:0]  exp_dcnt;
    logic [NA-1:0] exp_pend;
  } vec_t;
  vec_t tbl[9];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NA; i++) begin
      m_div[i] = '0; m_steps[i] = '0; m_dir[i] = 1'b0; m_pend[i] = 1'b0;
    end
    m_dcnt = 0;
  endtask

  task automatic model_start(input logic [NA-1:0] m);
    for (int i = 0; i < NA; i++)
      if (m[i]) begin m_pend[i] = 1'b0; m_steps[i] = '0; end
  endtask

  task automatic model_frame(input int ax, input logic [14:0] d, input logic [14:0] s,
                             input logic dr, output logic ok);
    if (ax < NA && !m_pend[ax]) begin
      m_div[ax] = d; m_steps[ax] = s; m_dir[ax] = dr; m_pend[ax] = 1'b1; ok = 1'b1;
    end else begin
      if (m_dcnt < 255) m_dcnt++;
      ok = 1'b0;
    end
  endtask

  task automatic check_all(input string tag);
    logic [15*NA-1:0] vd, vs;
    logic [NA-1:0]    vr, vp;
    for (int i = 0; i < NA; i++) begin
      vd[15*i +: 15] = m_div[i]; vs[15*i +: 15] = m_steps[i];
      vr[i] = m_dir[i]; vp[i] = m_pend[i];
    end
    check({tag, ".divider"}, divider_o, vd);
    check({tag, ".steps"}, steps_o, vs);
    check({tag, ".dir"}, dir_o, vr);
    check({tag, ".pending"}, pending_o, vp);
    check({tag, ".drop_cnt"}, drop_cnt, m_dcnt[7:0]);
  endtask

  function automatic logic [39:0] mk(input int ax, input logic [14:0] d, input logic [14:0] s,
                                     input logic dr, input logic [4:0] rsv);
    logic [3:0] a;
    a = ax[3:0];
    return {rsv, dr, s, d, a};
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1; rx_data = b;
    @(negedge CLK);
    rx_valid = 1'b0;
  endtask

  // Sends a frame, updates the model and checks the decode result 1 clk later.
  task automatic do_frame(input string tag, input int ax, input logic [14:0] d,
                          input logic [14:0] s, input logic dr, input logic [4:0] rsv,
                          input int gap, output logic ok);
    logic [39:0] f;
    f = mk(ax, d, s, dr, rsv);
    for (int j = 0; j < FB; j++) begin
      send_byte(f[8*j +: 8]);
      if (j < FB - 1) idle(gap);
    end
    @(negedge CLK);
    model_frame(ax, d, s, dr, ok);
    check({tag, ".frame_ok"}, frame_ok, ok);
    check({tag, ".frame_drop"}, frame_drop, !ok);
    check_all(tag);
  endtask

  task automatic pulse_start(input logic [NA-1:0] m);
    motor_active = m;
    @(negedge CLK);
    @(negedge CLK);
    motor_active = '0;
    @(negedge CLK);
    model_start(m);
  endtask

  task automatic do_reset();
    reset_n = 1'b0; rx_valid = 1'b0; motor_active = '0;
    idle(2);
    reset_n = 1'b1;
    @(negedge CLK);
    model_reset();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ok;
    logic [39:0] f;
    tbl[0] = '{-1, 3,  15'h00FF, 15'h0006, 1'b1, 1'b1, 8'd0, 10'h008};
    tbl[1] = '{ 3, 5,  15'h1234, 15'h7FFF, 1'b0, 1'b1, 8'd0, 10'h020};
    tbl[2] = '{-1, 5,  15'h0001, 15'h0002, 1'b1, 1'b0, 8'd1, 10'h020};
    tbl[3] = '{-1, 12, 15'h0055, 15'h0003, 1'b0, 1'b0, 8'd2, 10'h020};
    tbl[4] = '{-1, 15, 15'h0777, 15'h0004, 1'b1, 1'b0, 8'd3, 10'h020};
    tbl[5] = '{ 5, 5,  15'h7FFF, 15'h0000, 1'b1, 1'b1, 8'd3, 10'h020};
    tbl[6] = '{-1, 9,  15'h4000, 15'h0001, 1'b0, 1'b1, 8'd3, 10'h220};
    tbl[7] = '{-1, 0,  15'h2AAA, 15'h5555, 1'b1, 1'b1, 8'd3, 10'h221};
    tbl[8] = '{-1, 10, 15'h0123, 15'h0456, 1'b0, 1'b0, 8'd4, 10'h221};

    // reset state
    model_reset();
    reset_n = 1'b0;
    #1;
    check("reset.divider", divider_o, 0);
    check("reset.steps", steps_o, 0);
    check("reset.dir", dir_o, 0);
    check("reset.pending", pending_o, 0);
    check("reset.ok_drop", {frame_ok, frame_drop}, 0);
    check("reset.drop_cnt", drop_cnt, 0);
    do_reset();

    // table of frames, optionally preceded by a start pulse
    for (int r = 0; r < 9; r++) begin
      if (tbl[r].start_ax >= 0) begin
        logic [NA-1:0] m;
        m = '0; m[tbl[r].start_ax] = 1'b1;
        pulse_start(m);
        check_all($sformatf("tbl%0d.start", r));
      end
      do_frame($sformatf("tbl%0d", r), tbl[r].ax, tbl[r].dv, tbl[r].st, tbl[r].dr, 5'h1F, 3, ok);
      check($sformatf("tbl%0d.exp_ok", r), frame_ok, tbl[r].exp_ok);
      check($sformatf("tbl%0d.exp_dcnt", r), drop_cnt, tbl[r].exp_dcnt);
      check($sformatf("tbl%0d.exp_pend", r), pending_o, tbl[r].exp_pend);
      if (r == 0) begin
        @(negedge CLK);
        check("tbl0.ok_single_pulse", frame_ok, 1'b0);
      end
    end

    // simultaneous start edges on two axes clear both
    pulse_start(10'h201);
    check_all("multi_start");
    check("multi_start.pend", pending_o, 10'h020);

    // partial frame then long idle: discarded, next frame loads cleanly
    do_reset();
    send_byte(8'h07); send_byte(8'hAB);
    idle(TO + 2);
    do_frame("timeout", 0, 15'h0ABC, 15'h0010, 1'b1, 5'h00, 1, ok);
    check("timeout.dcnt0", drop_cnt, 8'd0);

    // gap one short of expiry: frame continues
    f = mk(1, 15'h0321, 15'h0654, 1'b0, 5'h00);
    send_byte(f[7:0]); send_byte(f[15:8]);
    idle(TO - 2);
    send_byte(f[23:16]); send_byte(f[31:24]); send_byte(f[39:32]);
    @(negedge CLK);
    model_frame(1, 15'h0321, 15'h0654, 1'b0, ok);
    check("to_edge_cont.ok", frame_ok, 1'b1);
    check_all("to_edge_cont");

    // gap exactly at expiry: the next byte is byte 0 of a new frame
    send_byte(8'h04); send_byte(8'h55);
    idle(TO - 1);
    do_frame("to_edge_restart", 2, 15'h0111, 15'h0222, 1'b1, 5'h00, 0, ok);

    // accept coincident with start edge on the same pending axis
    do_reset();
    do_frame("coinc.first", 2, 15'h0111, 15'h0022, 1'b0, 5'h00, 0, ok);
    f = mk(2, 15'h0333, 15'h0044, 1'b1, 5'h00);
    for (int j = 0; j < FB; j++) send_byte(f[8*j +: 8]);
    motor_active[2] = 1'b1;
    @(negedge CLK);
    model_start(10'h004);
    model_frame(2, 15'h0333, 15'h0044, 1'b1, ok);
    check("coinc.ok", frame_ok, 1'b1);
    check("coinc.drop", frame_drop, 1'b0);
    check_all("coinc");
    motor_active = '0;
    @(negedge CLK);

    // reset mid-frame: everything cleared, stale bytes gone
    do_frame("rst.pre", 4, 15'h0F0F, 15'h00F0, 1'b1, 5'h00, 0, ok);
    send_byte(8'h04); send_byte(8'h11); send_byte(8'h22);
    reset_n = 1'b0;
    #1;
    check("rst_mid.divider", divider_o, 0);
    check("rst_mid.steps", steps_o, 0);
    check("rst_mid.pending", pending_o, 0);
    check("rst_mid.dir", dir_o, 0);
    do_reset();
    do_frame("rst.post", 4, 15'h0BBB, 15'h0CCC, 1'b0, 5'h00, 0, ok);

    // drop counter saturation
    do_reset();
    for (int k = 1; k <= 257; k++) begin
      f = mk(15, 15'(k), 15'(k), 1'b0, 5'h00);
      for (int j = 0; j < FB; j++) send_byte(f[8*j +: 8]);
      model_frame(15, 15'(k), 15'(k), 1'b0, ok);
      if (k == 254 || k == 255 || k == 257) begin
        @(negedge CLK);
        check($sformatf("sat.dcnt%0d", k), drop_cnt, m_dcnt[7:0]);
        check($sformatf("sat.ref%0d", k), drop_cnt, (k < 255) ? 8'(k) : 8'hFF);
      end
    end

    // randomized traffic against the model
    do_reset();
    for (int it = 0; it < 200; it++) begin
      int op;
      op = $urandom_range(0, 9);
      if (op < 6) begin
        int ax;
        ax = (op < 5) ? $urandom_range(0, NA - 1) : $urandom_range(0, 15);
        do_frame($sformatf("rnd%0d", it), ax, 15'($urandom), 15'($urandom),
                 1'($urandom), 5'($urandom), $urandom_range(0, 4), ok);
      end else if (op < 9) begin
        pulse_start(NA'($urandom));
        check_all($sformatf("rnd%0d.start", it));
      end else begin
        repeat ($urandom_range(1, FB - 1)) send_byte(8'($urandom));
        idle(TO - 1 + $urandom_range(0, 3));
        check_all($sformatf("rnd%0d.partial", it));
      end
      idle($urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
